// File: rtl/switch_packet_receiver.sv
// Control-port packet receiver: frames DA/SA/LEN/payload/PARITY bytes, checks parity,
// buffers one good packet and replays it as a valid/ready byte stream.
module switch_packet_receiver #(
  parameter int MAX_LEN = 255
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       sw_enable_in,
  output logic       read_out,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       parity_error,
  output logic       framing_error,
  output logic       length_error,
  output logic       dropped
);

  localparam int DEPTH = MAX_LEN + 3;
  localparam int AW = $clog2(DEPTH);
  localparam logic [8:0] MAX_LEN_9 = 9'(MAX_LEN);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DA,
    ST_SA,
    ST_LEN,
    ST_PAYLOAD,
    ST_PARITY,
    ST_WAIT_LOW,
    ST_DROP
  } state_t;

  state_t          state_reg;
  logic            en_prev_reg;
  logic [7:0]      len_reg;
  logic [7:0]      cnt_reg;
  logic [7:0]      parity_acc_reg;
  logic [AW-1:0]   wr_ptr_reg;
  logic [AW-1:0]   rd_idx_reg;
  logic [AW-1:0]   last_idx_reg;
  logic            out_valid_reg;
  logic            out_last_reg;
  logic            read_out_reg;
  logic [7:0]      rd_data_reg;
  logic            parity_error_reg;
  logic            framing_error_reg;
  logic            length_error_reg;
  logic            dropped_reg;

  logic [7:0]      mem [0:DEPTH-1];

  logic            start;
  logic            in_frame;
  logic            wr_en;
  logic            commit;
  logic            beat_fire;
  logic            rd_en;
  logic [AW-1:0]   rd_addr;
  logic            idle_next;
  logic            occupied_next;

  assign start     = sw_enable_in && !en_prev_reg;
  assign in_frame  = (state_reg == ST_DA) || (state_reg == ST_SA) || (state_reg == ST_LEN) ||
                     (state_reg == ST_PAYLOAD) || (state_reg == ST_PARITY);
  assign wr_en     = sw_enable_in && ((state_reg == ST_DA) || (state_reg == ST_SA) ||
                     (state_reg == ST_LEN) || (state_reg == ST_PAYLOAD));
  assign commit    = sw_enable_in && (state_reg == ST_PARITY) && (data_in == parity_acc_reg);
  assign beat_fire = out_valid_reg && out_ready;
  // The commit edge prefetches beat 0; each non-final handshake prefetches the next beat.
  assign rd_en     = commit || (beat_fire && !out_last_reg);
  assign rd_addr   = commit ? '0 : rd_idx_reg + 1'b1;

  // Every non-IDLE state leaves to IDLE exactly when sw_enable_in is low.
  assign idle_next     = (state_reg == ST_IDLE) ? !start : !sw_enable_in;
  assign occupied_next = commit || (out_valid_reg && !(beat_fire && out_last_reg));

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg         <= ST_IDLE;
      en_prev_reg       <= 1'b1;
      len_reg           <= '0;
      cnt_reg           <= '0;
      parity_acc_reg    <= '0;
      wr_ptr_reg        <= '0;
      parity_error_reg  <= 1'b0;
      framing_error_reg <= 1'b0;
      length_error_reg  <= 1'b0;
      dropped_reg       <= 1'b0;
    end else begin
      en_prev_reg       <= sw_enable_in;
      parity_error_reg  <= 1'b0;
      framing_error_reg <= 1'b0;
      length_error_reg  <= 1'b0;
      dropped_reg       <= 1'b0;
      if (wr_en) begin
        wr_ptr_reg     <= wr_ptr_reg + 1'b1;
        parity_acc_reg <= parity_acc_reg ^ data_in;
      end
      if (in_frame && !sw_enable_in) begin
        framing_error_reg <= 1'b1;
        state_reg         <= ST_IDLE;
      end else begin
        case (state_reg)
          ST_IDLE: begin
            if (start) begin
              if (out_valid_reg) begin
                dropped_reg <= 1'b1;
                state_reg   <= ST_DROP;
              end else begin
                parity_acc_reg <= '0;
                wr_ptr_reg     <= '0;
                state_reg      <= ST_DA;
              end
            end
          end
          ST_DA: state_reg <= ST_SA;
          ST_SA: state_reg <= ST_LEN;
          ST_LEN: begin
            len_reg <= data_in;
            cnt_reg <= data_in;
            if ({1'b0, data_in} > MAX_LEN_9) begin
              length_error_reg <= 1'b1;
              state_reg        <= ST_WAIT_LOW;
            end else if (data_in == 8'd0) begin
              state_reg <= ST_PARITY;
            end else begin
              state_reg <= ST_PAYLOAD;
            end
          end
          ST_PAYLOAD: begin
            cnt_reg <= cnt_reg - 8'd1;
            if (cnt_reg == 8'd1) state_reg <= ST_PARITY;
          end
          ST_PARITY: begin
            if (!commit) parity_error_reg <= 1'b1;
            state_reg <= ST_WAIT_LOW;
          end
          ST_WAIT_LOW, ST_DROP: begin
            if (!sw_enable_in) state_reg <= ST_IDLE;
          end
          default: state_reg <= ST_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_ptr_reg] <= data_in;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_data_reg <= '0;
    end else if (rd_en) begin
      rd_data_reg <= mem[rd_addr];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid_reg <= 1'b0;
      out_last_reg  <= 1'b0;
      rd_idx_reg    <= '0;
      last_idx_reg  <= '0;
    end else if (commit) begin
      out_valid_reg <= 1'b1;
      out_last_reg  <= 1'b0;
      rd_idx_reg    <= '0;
      last_idx_reg  <= AW'(len_reg) + AW'(2);
    end else if (beat_fire) begin
      if (out_last_reg) begin
        out_valid_reg <= 1'b0;
        out_last_reg  <= 1'b0;
      end else begin
        rd_idx_reg   <= rd_idx_reg + 1'b1;
        out_last_reg <= (rd_idx_reg + 1'b1) == last_idx_reg;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      read_out_reg <= 1'b0;
    end else begin
      read_out_reg <= idle_next && !occupied_next;
    end
  end

  assign read_out      = read_out_reg;
  assign out_data      = rd_data_reg;
  assign out_valid     = out_valid_reg;
  assign out_last      = out_last_reg;
  assign parity_error  = parity_error_reg;
  assign framing_error = framing_error_reg;
  assign length_error  = length_error_reg;
  assign dropped       = dropped_reg;

endmodule

// File: tb/tb_switch_packet_receiver.sv
// Table-driven bench for switch_packet_receiver plus hand-written backpressure/drop and reset sequences.
module tb_switch_packet_receiver;

  localparam int MAX_LEN = 16;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] data_in;
  logic       sw_enable_in;
  logic       read_out;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       out_last;
  logic       parity_error;
  logic       framing_error;
  logic       length_error;
  logic       dropped;

  switch_packet_receiver #(.MAX_LEN(MAX_LEN)) dut (
    .clock        (clock),
    .reset        (reset),
    .data_in      (data_in),
    .sw_enable_in (sw_enable_in),
    .read_out     (read_out),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_last     (out_last),
    .parity_error (parity_error),
    .framing_error(framing_error),
    .length_error (length_error),
    .dropped      (dropped)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] da;
    logic [7:0] sa;
    logic [7:0] len;
    logic [7:0] pay_base;
    logic [7:0] pay_step;
    logic [7:0] parity;
    int         drop_at;
    int         n_extra;
    int         ready_mode;
    bit         exp_good;
    int         exp_par;
    int         exp_frm;
    int         exp_len;
  } vec_t;

  vec_t vecs[7];

  int checks = 0;
  int fails  = 0;
  int par_cnt, frm_cnt, len_cnt, drp_cnt;
  logic [8:0] beats[$];
  int ready_mode = 0;

  logic       prev_stall = 1'b0;
  logic       prev_final = 1'b0;
  logic [7:0] prev_data;
  logic       prev_last;

  // out_ready pattern: 0 always ready, 1 toggling, 2 stalled
  always @(posedge clock) begin
    #1;
    case (ready_mode)
      0: out_ready = 1'b1;
      1: out_ready = ~out_ready;
      default: out_ready = 1'b0;
    endcase
  end

  // Sample just before the active edge: record handshakes, pulses and hold behaviour
  always @(negedge clock) begin
    if (reset) begin
      prev_stall = 1'b0;
      prev_final = 1'b0;
    end else begin
      if (prev_stall) begin
        checks++;
        if (!(out_valid === 1'b1 && out_data === prev_data && out_last === prev_last)) begin
          fails++;
          $display("FAIL stall_hold: got valid=%0b data=%02h last=%0b, required valid=1 data=%02h last=%0b",
                   out_valid, out_data, out_last, prev_data, prev_last);
        end
      end
      if (prev_final) begin
        checks++;
        if (out_valid !== 1'b0) begin
          fails++;
          $display("FAIL post_last_valid: got %0b required 0", out_valid);
        end
      end
      if (parity_error)  par_cnt++;
      if (framing_error) frm_cnt++;
      if (length_error)  len_cnt++;
      if (dropped)       drp_cnt++;
      if (out_valid && out_ready) beats.push_back({out_last, out_data});
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
      prev_final = out_valid && out_ready && out_last;
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h required %0h", name, got, exp);
    end
  endtask

  task automatic clear_obs();
    beats.delete();
    par_cnt = 0;
    frm_cnt = 0;
    len_cnt = 0;
    drp_cnt = 0;
  endtask

  task automatic send_packet(input logic [7:0] da, input logic [7:0] sa, input logic [7:0] len,
                             input logic [7:0] base, input logic [7:0] step, input logic [7:0] parity,
                             input int drop_at, input int n_extra);
    logic [7:0] bytes[$];
    bytes.push_back(da);
    bytes.push_back(sa);
    bytes.push_back(len);
    for (int k = 0; k < int'(len); k++) bytes.push_back(base + 8'(k) * step);
    bytes.push_back(parity);
    for (int k = 0; k < n_extra; k++) bytes.push_back(8'hA0 + 8'(k));
    sw_enable_in = 1'b0;
    tick();
    sw_enable_in = 1'b1;
    data_in = 8'hEE;
    tick();
    check("read_out_after_start", read_out, 0);
    for (int i = 0; i < bytes.size(); i++) begin
      if (i == drop_at) begin
        sw_enable_in = 1'b0;
        data_in = 8'h00;
        tick();
        break;
      end
      sw_enable_in = 1'b1;
      data_in = bytes[i];
      tick();
    end
    sw_enable_in = 1'b0;
    tick();
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(read_out === 1'b1 && out_valid === 1'b0) && n < 300) begin
      tick();
      n++;
    end
    check("drain_not_timed_out", (n < 300), 1);
  endtask

  task automatic check_beats(input string tag, input logic [7:0] da, input logic [7:0] sa,
                             input logic [7:0] len, input logic [7:0] base, input logic [7:0] step);
    int nb = int'(len) + 3;
    check({tag, "_beat_count"}, beats.size(), nb);
    for (int b = 0; b < nb && b < beats.size(); b++) begin
      logic [7:0] e;
      if (b == 0) e = da;
      else if (b == 1) e = sa;
      else if (b == 2) e = len;
      else e = base + 8'(b - 3) * step;
      check($sformatf("%s_beat%0d_data", tag, b), beats[b][7:0], e);
      check($sformatf("%s_beat%0d_last", tag, b), beats[b][8], (b == nb - 1));
    end
  endtask

  initial begin
    vecs[0] = '{8'h0A, 8'h05, 8'h02, 8'h11, 8'h11, 8'h3E, -1, 0, 0, 1'b1, 0, 0, 0};
    vecs[1] = '{8'h01, 8'h02, 8'h00, 8'h00, 8'h00, 8'h03, -1, 0, 0, 1'b1, 0, 0, 0};
    vecs[2] = '{8'h0A, 8'h05, 8'h02, 8'h11, 8'h11, 8'h3F, -1, 0, 0, 1'b0, 1, 0, 0};
    vecs[3] = '{8'h0A, 8'h05, 8'h02, 8'h11, 8'h11, 8'h3E,  3, 0, 0, 1'b0, 0, 1, 0};
    vecs[4] = '{8'h0A, 8'h05, 8'h11, 8'h00, 8'h01, 8'h00, -1, 0, 0, 1'b0, 0, 0, 1};
    vecs[5] = '{8'h10, 8'h20, 8'h10, 8'h00, 8'h01, 8'h20, -1, 0, 1, 1'b1, 0, 0, 0};
    vecs[6] = '{8'h33, 8'h44, 8'h01, 8'h55, 8'h00, 8'h23, -1, 2, 1, 1'b1, 0, 0, 0};

    reset = 1'b1;
    sw_enable_in = 1'b0;
    data_in = 8'h00;
    tick();
    tick();
    check("reset_read_out", read_out, 0);
    check("reset_out_valid", out_valid, 0);
    check("reset_out_data", out_data, 0);
    check("reset_out_last", out_last, 0);
    check("reset_errors", {parity_error, framing_error, length_error, dropped}, 0);
    reset = 1'b0;
    tick();
    check("read_out_after_reset", read_out, 1);

    foreach (vecs[v]) begin
      clear_obs();
      ready_mode = vecs[v].ready_mode;
      send_packet(vecs[v].da, vecs[v].sa, vecs[v].len, vecs[v].pay_base, vecs[v].pay_step,
                  vecs[v].parity, vecs[v].drop_at, vecs[v].n_extra);
      wait_idle();
      tick();
      if (vecs[v].exp_good)
        check_beats($sformatf("vec%0d", v), vecs[v].da, vecs[v].sa, vecs[v].len,
                    vecs[v].pay_base, vecs[v].pay_step);
      else
        check($sformatf("vec%0d_no_beats", v), beats.size(), 0);
      check($sformatf("vec%0d_parity_err", v), par_cnt, vecs[v].exp_par);
      check($sformatf("vec%0d_framing_err", v), frm_cnt, vecs[v].exp_frm);
      check($sformatf("vec%0d_length_err", v), len_cnt, vecs[v].exp_len);
      check($sformatf("vec%0d_dropped", v), drp_cnt, 0);
      $display("vec%0d: len=%0d beats=%0d par=%0d frm=%0d lenerr=%0d", v, vecs[v].len,
               beats.size(), par_cnt, frm_cnt, len_cnt);
    end

    // Backpressure: first packet stalls at DA, a second start is dropped
    clear_obs();
    ready_mode = 2;
    tick();
    send_packet(8'h0A, 8'h05, 8'h02, 8'h11, 8'h11, 8'h3E, -1, 0);
    tick();
    check("bp_out_valid", out_valid, 1);
    check("bp_out_data", out_data, 8'h0A);
    check("bp_out_last", out_last, 0);
    check("bp_read_out", read_out, 0);
    send_packet(8'h77, 8'h66, 8'h01, 8'h10, 8'h00, 8'h00, -1, 0);
    tick();
    check("bp_dropped", drp_cnt, 1);
    check("bp_out_data_held", out_data, 8'h0A);
    check("bp_no_beats_yet", beats.size(), 0);
    ready_mode = 0;
    wait_idle();
    tick();
    check_beats("bp", 8'h0A, 8'h05, 8'h02, 8'h11, 8'h11);
    check("bp_other_errors", par_cnt + frm_cnt + len_cnt, 0);
    $display("backpressure: beats=%0d dropped=%0d", beats.size(), drp_cnt);

    // Reset mid-payload with sw_enable_in held high through deassertion
    clear_obs();
    sw_enable_in = 1'b0;
    tick();
    sw_enable_in = 1'b1;
    data_in = 8'hEE;
    tick();
    data_in = 8'h21; tick();
    data_in = 8'h22; tick();
    data_in = 8'h03; tick();
    data_in = 8'h44; tick();
    reset = 1'b1;
    data_in = 8'h55;
    tick();
    tick();
    reset = 1'b0;
    tick();
    data_in = 8'h66; tick();
    data_in = 8'h77; tick();
    check("rst_read_out_held_high", read_out, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_no_errors", par_cnt + frm_cnt + len_cnt + drp_cnt, 0);
    check("rst_no_beats", beats.size(), 0);
    send_packet(8'h01, 8'h02, 8'h00, 8'h00, 8'h00, 8'h03, -1, 0);
    wait_idle();
    tick();
    check_beats("rst", 8'h01, 8'h02, 8'h00, 8'h00, 8'h00);
    check("rst_errors_after", par_cnt + frm_cnt + len_cnt + drp_cnt, 0);
    $display("reset seq: beats=%0d", beats.size());

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
